ghost_sprite_reader: RTL and testbench
======================================

Name: ghost_sprite_reader

Overview:
- Read side of the 20x20 ghost sprite RAMs (400 entries x 24-bit RGB, 1-cycle registered read).
- Takes the VGA controller's DrawX/DrawY and the ghost's top-left position, and generates the sprite RAM read address.
- Absorbs the RAM read latency, applies the transparency key and frightened-mode recolouring with a frame-counted flash, and drives the pixel to the colour mapper.

Parameters:
SPRITE_W, 20, sprite width in pixels
SPRITE_H, 20, sprite height in pixels
ADDR_W, 9, sprite RAM address width
COLOR_W, 24, RGB pixel width
POS_W, 10, width of DrawX/DrawY/GhostX/GhostY
TRANSPARENT, 24'h000000, colour key treated as "no sprite pixel"
FLASH_PERIOD, 16, frames per flash phase in frightened-flash mode

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
DrawX  in  POS_W  current pixel column
DrawY  in  POS_W  current pixel row
pixel_valid  in  1  DrawX/DrawY are an active-video pixel this cycle
GhostX  in  POS_W  sprite top-left column
GhostY  in  POS_W  sprite top-left row
frame_start  in  1  one-cycle pulse at the start of each frame
frightened  in  1  ghost is in frightened mode
frightened_flash  in  1  frightened mode is ending; flash blue/white
ram_read_address  out  ADDR_W  to sprite RAM read_address
ram_data  in  COLOR_W  from sprite RAM data_Out
pix_color  out  COLOR_W  resolved pixel colour
pix_hit  out  1  sprite covers this pixel (non-transparent)
pix_valid_out  out  1  pixel_valid delayed to align with pix_color/pix_hit

Behaviour:
- Reset, asynchronous: all outputs and pipeline registers go to 0. This includes ram_read_address=0, pix_color=0, pix_hit=0, pix_valid_out=0, flash counter=0 and flash phase=0 (blue).
- In-box test uses POS_W+1-bit arithmetic, so there is no wrap. A pixel is in the box iff GhostX <= DrawX < GhostX+SPRITE_W, GhostY <= DrawY < GhostY+SPRITE_H, and pixel_valid=1.
- Address: dx=DrawX-GhostX, dy=DrawY-GhostY, addr=dy*SPRITE_W+dx, truncated to ADDR_W. Out of box gives addr=0.
- Stage 1 (edge t): register addr onto ram_read_address; register in_box and pixel_valid.
- Edge t+1: the RAM registers ram_data. Stage 2 registers in_box and pixel_valid again for alignment.
- Stage 3 (edge t+2): register pix_color, pix_hit and pix_valid_out.
- Fixed latency is 2 clocks from the sampling edge; throughput is 1 pixel per clock, with no stalls.
- Stage 3 resolution:
  - in_box=0 or ram_data==TRANSPARENT: pix_hit=0, pix_color=0.
  - Otherwise pix_hit=1 and pix_color follows the first matching case:
    - frightened=0: ram_data.
    - frightened=1, frightened_flash=0: 24'h2121FF.
    - frightened=1, frightened_flash=1: 24'h2121FF when phase=0, 24'hFFFFFF when phase=1.
- frightened and frightened_flash are sampled at stage 3, not pipelined.
- Flash counter:
  - Increments on frame_start while frightened_flash=1.
  - On reaching FLASH_PERIOD-1 with frame_start, it wraps to 0 and toggles phase.
  - frightened_flash=0 clears the counter and phase to 0 on the next edge.
- Simultaneous frame_start and frightened_flash deassert: clear wins.
- GhostX/GhostY changing mid-frame takes effect at the next stage 1 sample; there is no shadowing.
- Reset asserted mid-line flushes the pipeline. The first valid output after release appears 2 clocks after the first sampled pixel.

Optional Feature:
SPRITE_FLIP_X_EN
- Defined: adds input port flip_x (1 bit, sampled with DrawX at stage 1). When flip_x=1, dx is replaced by SPRITE_W-1-dx before address generation, so left-facing sprites are mirrored. The in-box test is unchanged.
- Undefined: no flip_x port; addressing exactly as above.

Test Plan:
- GhostX=100, GhostY=50, pixel_valid=1. DrawX=100, DrawY=50 -> ram_read_address=0. DrawX=119, DrawY=69 -> 399. DrawX=120 -> pix_hit=0 two clocks later, ram_read_address=0.
- Ghost at (100,50), DrawX=105, DrawY=51, RAM model returns 24'hFF0000 at address 25 -> two clocks later pix_color=FF0000, pix_hit=1, pix_valid_out=1.
- Same pixel with RAM returning 24'h000000 -> pix_hit=0, pix_color=0. pixel_valid=0 inside the box -> pix_hit=0, pix_valid_out=0.
- frightened=1, frightened_flash=0, ram_data=FF0000 -> pix_color=2121FF. Set frightened_flash=1, FLASH_PERIOD=4, pulse frame_start 4 times -> pix_color=FFFFFF; 4 more -> 2121FF. Drop frightened_flash -> phase 0.
- Stream 5 consecutive in-box pixels, assert Reset on the 3rd -> all outputs 0 immediately. Release, resume -> first pix_valid_out exactly 2 clocks after the first sampled pixel.
- Boundaries: GhostX=620, DrawX=639 in box (dx=19); GhostX=0, GhostY=0, DrawX=0, DrawY=0 hit at address 0. With SPRITE_FLIP_X_EN and flip_x=1: DrawX=100, DrawY=50 (ghost at 100,50) -> ram_read_address=19.

Source files
------------

// File: rtl/ghost_sprite_reader.sv
// Ghost sprite RAM read side: address generation, latency alignment, transparency and frightened recolouring.
// Optional mirrored addressing is enabled with `define SPRITE_FLIP_X_EN (adds the flip_x input).
module ghost_sprite_reader #(
    parameter int                 SPRITE_W     = 20,
    parameter int                 SPRITE_H     = 20,
    parameter int                 ADDR_W       = 9,
    parameter int                 COLOR_W      = 24,
    parameter int                 POS_W        = 10,
    parameter logic [COLOR_W-1:0] TRANSPARENT  = 24'h000000,
    parameter int                 FLASH_PERIOD = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [POS_W-1:0]   DrawX,
    input  logic [POS_W-1:0]   DrawY,
    input  logic               pixel_valid,
    input  logic [POS_W-1:0]   GhostX,
    input  logic [POS_W-1:0]   GhostY,
    input  logic               frame_start,
    input  logic               frightened,
    input  logic               frightened_flash,
`ifdef SPRITE_FLIP_X_EN
    input  logic               flip_x,
`endif
    output logic [ADDR_W-1:0]  ram_read_address,
    input  logic [COLOR_W-1:0] ram_data,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_hit,
    output logic               pix_valid_out
);

    localparam int PW     = POS_W + 1;
    localparam int PROD_W = 2 * PW;
    localparam int CNT_W  = $clog2(FLASH_PERIOD + 1);

    localparam logic [COLOR_W-1:0] FRIGHT_BLUE = 24'h2121FF;
    localparam logic [COLOR_W-1:0] FLASH_WHITE = 24'hFFFFFF;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(FLASH_PERIOD - 1);

    logic [PW-1:0]      draw_x_s;
    logic [PW-1:0]      draw_y_s;
    logic [PW-1:0]      ghost_x_s;
    logic [PW-1:0]      ghost_y_s;
    logic [PW-1:0]      x_end_s;
    logic [PW-1:0]      y_end_s;
    logic [PW-1:0]      dx_s;
    logic [PW-1:0]      dy_s;
    logic [PW-1:0]      dx_eff_s;
    logic               in_box_s;
    logic [PROD_W-1:0]  addr_wide_s;
    logic [ADDR_W-1:0]  addr_s;

    logic               in_box_r1;
    logic               valid_r1;
    logic               in_box_r2;
    logic               valid_r2;

    logic [CNT_W-1:0]   flash_cnt_r;
    logic               flash_phase_r;
    logic [CNT_W-1:0]   flash_cnt_next_s;
    logic               flash_phase_next_s;

    logic [COLOR_W-1:0] color_next_s;
    logic               hit_next_s;

    // Box test and sprite-relative address, widened by one bit so box edges never wrap.
    always_comb begin
        draw_x_s  = {1'b0, DrawX};
        draw_y_s  = {1'b0, DrawY};
        ghost_x_s = {1'b0, GhostX};
        ghost_y_s = {1'b0, GhostY};
        x_end_s   = ghost_x_s + PW'(SPRITE_W);
        y_end_s   = ghost_y_s + PW'(SPRITE_H);
        dx_s      = draw_x_s - ghost_x_s;
        dy_s      = draw_y_s - ghost_y_s;
        in_box_s  = pixel_valid
                    && (draw_x_s >= ghost_x_s) && (draw_x_s < x_end_s)
                    && (draw_y_s >= ghost_y_s) && (draw_y_s < y_end_s);
`ifdef SPRITE_FLIP_X_EN
        if (flip_x) begin
            dx_eff_s = PW'(SPRITE_W - 1) - dx_s;
        end else begin
            dx_eff_s = dx_s;
        end
`else
        dx_eff_s  = dx_s;
`endif
        addr_wide_s = PROD_W'(dy_s) * PROD_W'(SPRITE_W) + PROD_W'(dx_eff_s);
        if (in_box_s) begin
            addr_s = addr_wide_s[ADDR_W-1:0];
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Flash phase advance; dropping frightened_flash clears even when frame_start coincides.
    always_comb begin
        flash_cnt_next_s   = flash_cnt_r;
        flash_phase_next_s = flash_phase_r;
        if (!frightened_flash) begin
            flash_cnt_next_s   = {CNT_W{1'b0}};
            flash_phase_next_s = 1'b0;
        end else if (frame_start) begin
            if (flash_cnt_r == CNT_LAST) begin
                flash_cnt_next_s   = {CNT_W{1'b0}};
                flash_phase_next_s = ~flash_phase_r;
            end else begin
                flash_cnt_next_s   = flash_cnt_r + CNT_W'(1'b1);
                flash_phase_next_s = flash_phase_r;
            end
        end else begin
            flash_cnt_next_s   = flash_cnt_r;
            flash_phase_next_s = flash_phase_r;
        end
    end

    // Final colour: mode inputs are taken live here, only the box flag travels with the pixel.
    always_comb begin
        hit_next_s   = 1'b0;
        color_next_s = {COLOR_W{1'b0}};
        if (in_box_r2 && (ram_data != TRANSPARENT)) begin
            hit_next_s = 1'b1;
            if (!frightened) begin
                color_next_s = ram_data;
            end else if (!frightened_flash) begin
                color_next_s = FRIGHT_BLUE;
            end else if (flash_phase_r) begin
                color_next_s = FLASH_WHITE;
            end else begin
                color_next_s = FRIGHT_BLUE;
            end
        end else begin
            hit_next_s   = 1'b0;
            color_next_s = {COLOR_W{1'b0}};
        end
    end

    // Three-stage pixel pipeline around the one-cycle sprite RAM, plus the flash state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ram_read_address <= {ADDR_W{1'b0}};
            in_box_r1        <= 1'b0;
            valid_r1         <= 1'b0;
            in_box_r2        <= 1'b0;
            valid_r2         <= 1'b0;
            pix_color        <= {COLOR_W{1'b0}};
            pix_hit          <= 1'b0;
            pix_valid_out    <= 1'b0;
            flash_cnt_r      <= {CNT_W{1'b0}};
            flash_phase_r    <= 1'b0;
        end else begin
            ram_read_address <= addr_s;
            in_box_r1        <= in_box_s;
            valid_r1         <= pixel_valid;
            in_box_r2        <= in_box_r1;
            valid_r2         <= valid_r1;
            pix_color        <= color_next_s;
            pix_hit          <= hit_next_s;
            pix_valid_out    <= valid_r2;
            flash_cnt_r      <= flash_cnt_next_s;
            flash_phase_r    <= flash_phase_next_s;
        end
    end

endmodule

// File: tb/tb_ghost_sprite_reader.sv
// Directed bench for ghost_sprite_reader with a two-deep expectation queue and a behavioural sprite RAM.
module tb_ghost_sprite_reader;

    localparam int FP = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, GhostX, GhostY;
    logic        pixel_valid, frame_start, frightened, frightened_flash;
`ifdef SPRITE_FLIP_X_EN
    logic        flip_x;
`endif
    logic [8:0]  ram_read_address;
    logic [23:0] ram_data, pix_color;
    logic        pix_hit, pix_valid_out;

    logic [23:0] mem [0:511];
    int          checks = 0;
    int          errors = 0;
    int          m_cnt;
    logic        m_phase;
    logic        flip_m;

    typedef struct packed {
        logic       v;
        logic       ib;
        logic [8:0] a;
    } ent_t;
    ent_t pipe[$];

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) ram_data <= mem[ram_read_address];

    ghost_sprite_reader #(.FLASH_PERIOD(FP)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pixel_valid(pixel_valid), .GhostX(GhostX), .GhostY(GhostY),
        .frame_start(frame_start), .frightened(frightened),
        .frightened_flash(frightened_flash),
`ifdef SPRITE_FLIP_X_EN
        .flip_x(flip_x),
`endif
        .ram_read_address(ram_read_address), .ram_data(ram_data),
        .pix_color(pix_color), .pix_hit(pix_hit), .pix_valid_out(pix_valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model_px();
        int   x, y, gx, gy, dx;
        ent_t e;
        x  = int'(DrawX);
        y  = int'(DrawY);
        gx = int'(GhostX);
        gy = int'(GhostY);
        e.v  = pixel_valid;
        e.ib = pixel_valid && (x >= gx) && (x < gx + 20) && (y >= gy) && (y < gy + 20);
        dx = x - gx;
        if (flip_m) dx = 19 - dx;
        e.a = e.ib ? 9'((y - gy) * 20 + dx) : 9'd0;
        return e;
    endfunction

    // One clock: queue the driven pixel, predict the pixel leaving the pipeline, then compare.
    task automatic tick();
        ent_t        cur, old;
        logic [23:0] d, ec;
        logic        eh;
        cur = model_px();
        pipe.push_back(cur);
        old = pipe.pop_front();
        d  = mem[old.a];
        eh = old.ib && (d != 24'h000000);
        if (!eh)                                ec = 24'h000000;
        else if (!frightened)                   ec = d;
        else if (!frightened_flash || !m_phase) ec = 24'h2121FF;
        else                                    ec = 24'hFFFFFF;
        if (!frightened_flash) begin
            m_cnt = 0; m_phase = 1'b0;
        end else if (frame_start) begin
            if (m_cnt == FP - 1) begin m_cnt = 0; m_phase = ~m_phase; end
            else m_cnt++;
        end
        @(posedge Clk); #1;
        chk("addr", 32'(ram_read_address), 32'(cur.a));
        chk("valid_out", 32'(pix_valid_out), 32'(old.v));
        chk("hit", 32'(pix_hit), 32'(eh));
        chk("color", 32'(pix_color), 32'(ec));
    endtask

    task automatic px(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) tick();
        pixel_valid = 1'b1;
    endtask

    task automatic flush_model();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        m_cnt   = 0;
        m_phase = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 24'h400000 | 24'(i * 7 + 1);
        Reset = 1'b1; DrawX = '0; DrawY = '0; GhostX = '0; GhostY = '0;
        pixel_valid = 1'b0; frame_start = 1'b0; frightened = 1'b0; frightened_flash = 1'b0;
        flip_m = 1'b0;
`ifdef SPRITE_FLIP_X_EN
        flip_x = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_addr", 32'(ram_read_address), 32'd0);
        chk("rst_color", 32'(pix_color), 32'd0);
        chk("rst_hit", 32'(pix_hit), 32'd0);
        chk("rst_valid", 32'(pix_valid_out), 32'd0);
        Reset = 1'b0;
        flush_model();

        // Corner addresses and the right-hand edge
        GhostX = 10'd100; GhostY = 10'd50; pixel_valid = 1'b1;
        px(100, 50); chk("addr_tl", 32'(ram_read_address), 32'd0);
        px(119, 69); chk("addr_br", 32'(ram_read_address), 32'd399);
        px(120, 69); chk("addr_out", 32'(ram_read_address), 32'd0);
        idle(2);     chk("edge_miss", 32'(pix_hit), 32'd0);

        // Opaque, transparent and not-valid pixels
        mem[25] = 24'hFF0000;
        px(105, 51); idle(2);
        chk("red_color", 32'(pix_color), 32'hFF0000);
        chk("red_hit", 32'(pix_hit), 32'd1);
        mem[25] = 24'h000000;
        px(105, 51); idle(2);
        chk("transp_hit", 32'(pix_hit), 32'd0);
        pixel_valid = 1'b0; px(105, 51); idle(2);
        chk("novalid_out", 32'(pix_valid_out), 32'd0);

        // Frightened colouring and frame-counted flash
        mem[25] = 24'hFF0000;
        frightened = 1'b1;
        repeat (3) px(105, 51);
        chk("fright_blue", 32'(pix_color), 32'h2121FF);
        frightened_flash = 1'b1;
        frame_start = 1'b1; repeat (4) px(105, 51);
        frame_start = 1'b0; repeat (2) px(105, 51);
        chk("flash_white", 32'(pix_color), 32'hFFFFFF);
        frame_start = 1'b1; repeat (4) px(105, 51);
        frame_start = 1'b0; repeat (2) px(105, 51);
        chk("flash_blue", 32'(pix_color), 32'h2121FF);
        frame_start = 1'b1; repeat (4) px(105, 51);
        frightened_flash = 1'b0; px(105, 51);
        frame_start = 1'b0;
        frightened_flash = 1'b1; repeat (3) px(105, 51);
        chk("flash_cleared", 32'(pix_color), 32'h2121FF);
        frightened = 1'b0; frightened_flash = 1'b0;
        idle(2);

        // Reset in the middle of a five-pixel run
        px(101, 52); px(102, 52);
        DrawX = 10'd103;
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(ram_read_address), 32'd0);
        chk("mid_rst_color", 32'(pix_color), 32'd0);
        chk("mid_rst_hit", 32'(pix_hit), 32'd0);
        chk("mid_rst_valid", 32'(pix_valid_out), 32'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        flush_model();
        idle(1);
        px(103, 52); px(104, 52); px(105, 52);
        chk("first_after_rst", 32'(pix_valid_out), 32'd1);
        idle(2);

        // Screen-edge and origin boundaries, ghost moved between pixels
        GhostX = 10'd620; GhostY = 10'd50;
        px(639, 55); chk("addr_dx19", 32'(ram_read_address), 32'd119);
        px(640, 55);
        GhostX = 10'd0; GhostY = 10'd0;
        px(0, 0);
        GhostX = 10'd100; GhostY = 10'd50;
        px(110, 60);
        GhostX = 10'd105;
        px(110, 60);
        idle(2);
`ifdef SPRITE_FLIP_X_EN
        flip_x = 1'b1; flip_m = 1'b1;
        px(100, 50); chk("flip_addr", 32'(ram_read_address), 32'd19);
        px(119, 50);
        flip_x = 1'b0; flip_m = 1'b0;
        idle(2);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
